pw_sync_fifo_param: RTL

Parametrised single-clock capture FIFO, the successor to the dual-clock capture FIFO for frontends that run on the USB clock domain.
- Adds generic width and depth, runtime-programmable full and empty thresholds, an occupancy count, a high-water mark, and gated writes with sticky error flags.
- Sits between the fe_capture_<frontend> write side and the reg_main read path.
- Status bits are indexed by the FIFO_STAT_* defines in defines_pw.v.

---
 rtl/pw_sync_fifo_param.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/pw_sync_fifo_param.sv
// pw_sync_fifo_param: single-clock capture FIFO with programmable thresholds,
// occupancy count, high-water mark and sticky overflow/underflow flags.
module pw_sync_fifo_param #(
  parameter  int DATA_W = 18,
  parameter  int ADDR_W = 13,
  localparam int CNT_W  = ADDR_W + 1
) (
  input  logic              cwusb_clk,
  input  logic              reset_i,
  input  logic              I_fifo_flush,
  input  logic              I_custom_fifo_stat_flag,
  input  logic [DATA_W-1:0] I_data,
  input  logic              I_wr,
  output logic              O_fifo_write_allowed,
  input  logic              I_fifo_read,
  output logic [DATA_W-1:0] O_data,
  output logic              O_data_valid,
  input  logic [CNT_W-1:0]  I_full_threshold,
  input  logic [CNT_W-1:0]  I_empty_threshold,
  input  logic              I_clear_read_flags,
  input  logic              I_clear_write_flags,
  output logic              O_fifo_full,
  output logic              O_fifo_empty,
  output logic              O_fifo_overflow_blocked,
  output logic [CNT_W-1:0]  O_fifo_count,
  output logic [CNT_W-1:0]  O_high_water,
  output logic [5:0]        O_fifo_status
);

  localparam int DEPTH = 2 ** ADDR_W;

  // Status bit positions (match the FIFO_STAT_* indices used by reg_main).
  localparam int STAT_EMPTY            = 0;
  localparam int STAT_UNDERFLOW        = 1;
  localparam int STAT_EMPTY_THRESHOLD  = 2;
  localparam int STAT_FULL             = 3;
  localparam int STAT_OVERFLOW_BLOCKED = 4;
  localparam int STAT_CUSTOM_FLAG      = 5;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  high_water_q, high_water_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;

  logic              full, empty, write_allowed, empty_thr_hit;
  logic              wr_acc, rd_acc, wr_blocked, rd_under;
  logic [CNT_W-1:0]  eff_full_thr;

  // Flags decoded from the registered count and the live threshold inputs.
  always_comb begin
    full          = (count_q == CNT_W'(DEPTH));
    empty         = (count_q == '0);
    eff_full_thr  = (I_full_threshold > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : I_full_threshold;
    write_allowed = (count_q < eff_full_thr);
    empty_thr_hit = ~empty & (count_q <= I_empty_threshold);
    // Full is judged before the read, so a write at full is dropped even
    // when a read is accepted in the same cycle.
    wr_acc        = I_wr & ~full & ~I_fifo_flush;
    rd_acc        = I_fifo_read & ~empty & ~I_fifo_flush;
    wr_blocked    = I_wr & ~write_allowed & ~I_fifo_flush;
    rd_under      = I_fifo_read & empty & ~I_fifo_flush;
  end

  // Next-state for pointers, count, read data, high-water mark and sticky flags.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    data_d       = data_q;
    valid_d      = 1'b0;
    high_water_d = high_water_q;
    overflow_d   = overflow_q;
    underflow_d  = underflow_q;

    if (I_fifo_flush) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_acc) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
        data_d   = mem_q[rd_ptr_q[ADDR_W-1:0]];
        valid_d  = 1'b1;
      end
      count_d = count_q + CNT_W'(wr_acc) - CNT_W'(rd_acc);
    end

    if (I_clear_write_flags)   high_water_d = count_d;
    else if (count_d > high_water_q) high_water_d = count_d;

    if (wr_blocked)               overflow_d = 1'b1;
    else if (I_clear_write_flags) overflow_d = 1'b0;

    if (rd_under)                 underflow_d = 1'b1;
    else if (I_clear_read_flags)  underflow_d = 1'b0;
  end

  // Control and status registers, cleared by the asynchronous reset.
  always_ff @(posedge cwusb_clk or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      high_water_q <= '0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      high_water_q <= high_water_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
    end
  end

  // Storage write port.
  always_ff @(posedge cwusb_clk) begin
    // NOTE: storage has no reset so it maps onto block RAM; the pointers
    // being reset is what makes stale contents unreachable.
    if (wr_acc) mem_q[wr_ptr_q[ADDR_W-1:0]] <= I_data;
  end

  assign O_fifo_write_allowed    = write_allowed;
  assign O_data                  = data_q;
  assign O_data_valid            = valid_q;
  assign O_fifo_full             = full;
  assign O_fifo_empty            = empty;
  assign O_fifo_overflow_blocked = overflow_q;
  assign O_fifo_count            = count_q;
  assign O_high_water            = high_water_q;

  // Status vector assembly.
  always_comb begin
    O_fifo_status                        = '0;
    O_fifo_status[STAT_EMPTY]            = empty;
    O_fifo_status[STAT_UNDERFLOW]        = underflow_q;
    O_fifo_status[STAT_EMPTY_THRESHOLD]  = empty_thr_hit;
    O_fifo_status[STAT_FULL]             = full;
    O_fifo_status[STAT_OVERFLOW_BLOCKED] = overflow_q;
    O_fifo_status[STAT_CUSTOM_FLAG]      = I_custom_fifo_stat_flag;
  end

endmodule
